// File: rtl/bgr_collision_monitor.sv
// bgr_collision_monitor: per-frame probe-based collision detection for up to
// four bikes, watching the VGA pixel-fetch stream against the selected
// background colour.
module bgr_collision_monitor #(
  parameter int NUM_BIKES     = 2,
  parameter int ADDR_W        = 19,
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int PROBE_AHEAD   = 16,
  parameter int PROBE_SIDE    = 5,
  parameter int HIT_THRESH    = 1,
  parameter int WALL_IS_CRASH = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [4:0]                  background,
  input  logic                        frame_start,
  input  logic                        frame_end,
  input  logic                        pix_valid,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [23:0]                 pix_data,
  input  logic [NUM_BIKES*ADDR_W-1:0] bike_loc,
  input  logic [NUM_BIKES*3-1:0]      bike_orient,
  input  logic [NUM_BIKES-1:0]        clear_collided,
  output logic [NUM_BIKES-1:0]        collided,
  output logic                        crash_pulse,
  output logic                        busy
);

  localparam int PW = ADDR_W + 2;

  localparam logic signed [PW-1:0] FRAME_PIX = PW'(H_RES * V_RES);
  localparam logic signed [PW-1:0] OFS_A     = PW'(PROBE_AHEAD);
  localparam logic signed [PW-1:0] OFS_S     = PW'(PROBE_SIDE);
  localparam logic signed [PW-1:0] OFS_AH    = PW'(PROBE_AHEAD * H_RES);
  localparam logic signed [PW-1:0] OFS_SH    = PW'(PROBE_SIDE * H_RES);
  localparam logic [3:0]           THRESH4   = 4'(HIT_THRESH);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EVAL
  } state_t;

  state_t state_q, state_d;
  logic   snapshot;

  logic [4:0]           bg_q;
  logic [23:0]          bg_colour;
  logic                 bg_known;
  logic                 foreign;
  logic                 scan_pix;
  logic [NUM_BIKES-1:0] reach;
  logic [NUM_BIKES-1:0] newly;

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state; frame_start takes priority over frame_end while scanning
  always_comb begin
    state_d  = state_q;
    snapshot = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d  = SCAN;
          snapshot = 1'b1;
        end
      end
      SCAN: begin
        if (frame_start) begin
          snapshot = 1'b1;
        end else if (frame_end) begin
          state_d = EVAL;
        end
      end
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // background select latched with the bike snapshot
  always_ff @(posedge clock) begin
    if (reset) begin
      bg_q <= '0;
    end else if (snapshot) begin
      bg_q <= background;
    end
  end

  // background colour lookup; unknown selects never flag a pixel as foreign
  always_comb begin
    bg_colour = '0;
    bg_known  = 1'b1;
    case (bg_q)
      5'd0, 5'd1: bg_colour = 24'h000000;
      5'd2:       bg_colour = 24'h0C1530;
      5'd3:       bg_colour = 24'h3A3A3A;
      5'd4:       bg_colour = 24'h121428;
      default:    bg_known  = 1'b0;
    endcase
  end

  assign foreign  = bg_known && (pix_data != bg_colour);
  assign scan_pix = (state_q == SCAN) && pix_valid && foreign;

  for (genvar g = 0; g < NUM_BIKES; g++) begin : g_bike
    logic [ADDR_W-1:0]    loc_in;
    logic [2:0]           orient_in;
    logic signed [PW-1:0] loc_ext;
    logic signed [PW-1:0] pa, pb;
    logic                 active;
    logic                 on_a, on_b;
    logic                 wall;
    logic [ADDR_W-1:0]    probe_a_q, probe_b_q;
    logic                 live_a_q, live_b_q;
    logic [3:0]           hits_q;
    logic                 hit;

    assign loc_in    = bike_loc[g*ADDR_W +: ADDR_W];
    assign orient_in = bike_orient[g*3 +: 3];
    assign loc_ext   = signed'({2'b00, loc_in});
    assign active    = (orient_in[2] == 1'b0);

    // probes are computed from the live inputs and captured at snapshot
    always_comb begin
      pa = '0;
      pb = '0;
      case (orient_in)
        3'd0: begin
          pa = loc_ext - OFS_S - OFS_AH;
          pb = loc_ext + OFS_S - OFS_AH;
        end
        3'd1: begin
          pa = loc_ext - OFS_A - OFS_SH;
          pb = loc_ext - OFS_A + OFS_SH;
        end
        3'd2: begin
          pa = loc_ext + OFS_S + OFS_AH;
          pb = loc_ext - OFS_S + OFS_AH;
        end
        3'd3: begin
          pa = loc_ext + OFS_A - OFS_SH;
          pb = loc_ext + OFS_A + OFS_SH;
        end
        default: begin
          pa = '0;
          pb = '0;
        end
      endcase
    end

    assign on_a = !pa[PW-1] && (pa < FRAME_PIX);
    assign on_b = !pb[PW-1] && (pb < FRAME_PIX);
    assign wall = (WALL_IS_CRASH != 0) && active && !(on_a && on_b);

    // a probe match on both probes in one cycle still counts once
    assign hit = scan_pix &&
                 ((live_a_q && (addr == probe_a_q)) ||
                  (live_b_q && (addr == probe_b_q)));

    // snapshot and per-frame saturating hit counter
    always_ff @(posedge clock) begin
      if (reset) begin
        probe_a_q <= '0;
        probe_b_q <= '0;
        live_a_q  <= 1'b0;
        live_b_q  <= 1'b0;
        hits_q    <= '0;
      end else if (snapshot) begin
        probe_a_q <= pa[ADDR_W-1:0];
        probe_b_q <= pb[ADDR_W-1:0];
        live_a_q  <= active && on_a;
        live_b_q  <= active && on_b;
        hits_q    <= wall ? THRESH4 : 4'd0;
      end else if (hit && (hits_q != 4'hF)) begin
        hits_q <= hits_q + 4'd1;
      end
    end

    assign reach[g] = (hits_q >= THRESH4);
  end

  // a set coinciding with a clear of the same bit still counts as new
  assign newly = reach & ~(collided & ~clear_collided);

  // sticky flags and crash pulse, updated in the EVAL cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      collided    <= '0;
      crash_pulse <= 1'b0;
    end else begin
      crash_pulse <= 1'b0;
      if (state_q == EVAL) begin
        collided    <= (collided & ~clear_collided) | reach;
        crash_pulse <= |newly;
      end else begin
        collided <= collided & ~clear_collided;
      end
    end
  end

endmodule

// File: tb/tb_bgr_collision_monitor.sv
// tb_bgr_collision_monitor: directed vectors against three parameterisations
// (default, HIT_THRESH=2, WALL_IS_CRASH=0) sharing one stimulus stream.
module tb_bgr_collision_monitor;

  localparam int AW = 19;

  localparam logic [AW-1:0] L0      = 19'd64320;   // row 100, col 320
  localparam logic [AW-1:0] UP_A    = 19'd54075;
  localparam logic [AW-1:0] UP_B    = 19'd54085;
  localparam logic [AW-1:0] RT_A    = 19'd61136;
  localparam logic [AW-1:0] RT_B    = 19'd67536;
  localparam logic [AW-1:0] WALL_UP = 19'd3520;    // row 5, col 320
  localparam logic [AW-1:0] WALL_DN = 19'd304320;  // row 475, col 320

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    background;
  logic          frame_start;
  logic          frame_end;
  logic          pix_valid;
  logic [AW-1:0] addr;
  logic [23:0]   pix_data;
  logic [2*AW-1:0] bike_loc;
  logic [5:0]    bike_orient;
  logic [1:0]    clear_collided;

  logic [1:0] collided, collided_t2, collided_nw;
  logic       crash_pulse, crash_t2, crash_nw;
  logic       busy, busy_t2, busy_nw;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  bgr_collision_monitor #(.NUM_BIKES(2)) dut (
    .clock(clock), .reset(reset), .background(background),
    .frame_start(frame_start), .frame_end(frame_end), .pix_valid(pix_valid),
    .addr(addr), .pix_data(pix_data), .bike_loc(bike_loc),
    .bike_orient(bike_orient), .clear_collided(clear_collided),
    .collided(collided), .crash_pulse(crash_pulse), .busy(busy)
  );

  bgr_collision_monitor #(.NUM_BIKES(2), .HIT_THRESH(2)) dut_t2 (
    .clock(clock), .reset(reset), .background(background),
    .frame_start(frame_start), .frame_end(frame_end), .pix_valid(pix_valid),
    .addr(addr), .pix_data(pix_data), .bike_loc(bike_loc),
    .bike_orient(bike_orient), .clear_collided(clear_collided),
    .collided(collided_t2), .crash_pulse(crash_t2), .busy(busy_t2)
  );

  bgr_collision_monitor #(.NUM_BIKES(2), .WALL_IS_CRASH(0)) dut_nw (
    .clock(clock), .reset(reset), .background(background),
    .frame_start(frame_start), .frame_end(frame_end), .pix_valid(pix_valid),
    .addr(addr), .pix_data(pix_data), .bike_loc(bike_loc),
    .bike_orient(bike_orient), .clear_collided(clear_collided),
    .collided(collided_nw), .crash_pulse(crash_nw), .busy(busy_nw)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // all tasks start and end just after a falling edge
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic start_frame(input logic [4:0] bg,
                             input logic [AW-1:0] l0, input logic [2:0] o0,
                             input logic [AW-1:0] l1, input logic [2:0] o1);
    background  = bg;
    bike_loc    = {l1, l0};
    bike_orient = {o1, o0};
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic pixel(input logic [AW-1:0] a, input logic [23:0] d);
    pix_valid = 1'b1;
    addr      = a;
    pix_data  = d;
    @(negedge clock);
    pix_valid = 1'b0;
    addr      = '0;
    pix_data  = '0;
  endtask

  // any pixel already on the bus is presented together with frame_end
  task automatic end_frame(input string tag, input logic [1:0] prev,
                           input logic [1:0] exp_col, input logic exp_pulse,
                           input logic [1:0] clr);
    frame_end = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
    pix_valid = 1'b0;
    addr      = '0;
    pix_data  = '0;
    check($sformatf("%s_eval_busy", tag), 32'(busy), 32'd1);
    check($sformatf("%s_eval_hold", tag), 32'(collided), 32'(prev));
    check($sformatf("%s_eval_nopulse", tag), 32'(crash_pulse), 32'd0);
    clear_collided = clr;
    @(negedge clock);
    clear_collided = '0;
    check($sformatf("%s_col", tag), 32'(collided), 32'(exp_col));
    check($sformatf("%s_pulse", tag), 32'(crash_pulse), 32'(exp_pulse));
    @(negedge clock);
    check($sformatf("%s_pulse_end", tag), 32'(crash_pulse), 32'd0);
    check($sformatf("%s_idle", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    background     = '0;
    frame_start    = 1'b0;
    frame_end      = 1'b0;
    pix_valid      = 1'b0;
    addr           = '0;
    pix_data       = '0;
    bike_loc       = '0;
    bike_orient    = {3'd4, 3'd4};
    clear_collided = '0;
    @(negedge clock);
    @(negedge clock);
    check("rst_col", 32'(collided), 32'd0);
    check("rst_pulse", 32'(crash_pulse), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_col_t2", 32'(collided_t2), 32'd0);
    check("rst_col_nw", 32'(collided_nw), 32'd0);
    check("rst_pulse_t2", 32'(crash_t2 | crash_nw), 32'd0);
    check("rst_busy_t2", 32'(busy_t2 | busy_nw), 32'd0);
    reset = 1'b0;

    // up-facing hit on bg 0; inputs scrambled mid-frame must be ignored
    start_frame(5'd0, L0, 3'd0, '0, 3'd4);
    check("a_scan_busy", 32'(busy), 32'd1);
    bike_loc    = '0;
    bike_orient = {3'd4, 3'd3};
    background  = 5'd9;
    pixel(UP_A, 24'hFFFFFF);
    end_frame("a", 2'b00, 2'b01, 1'b1, 2'b00);
    check("a_t2", 32'(collided_t2), 32'd0);
    check("a_nw", 32'(collided_nw), 32'd1);

    // background-coloured and off-probe pixels are not hits
    do_reset();
    start_frame(5'd0, L0, 3'd0, '0, 3'd4);
    pixel(UP_A, 24'h000000);
    pixel(19'd54076, 24'hFFFFFF);
    end_frame("b", 2'b00, 2'b00, 1'b0, 2'b00);

    do_reset();
    start_frame(5'd2, L0, 3'd0, '0, 3'd4);
    pixel(UP_A, 24'h0C1530);
    end_frame("c", 2'b00, 2'b00, 1'b0, 2'b00);

    do_reset();
    start_frame(5'd2, L0, 3'd0, '0, 3'd4);
    pixel(UP_A, 24'h000000);
    end_frame("d", 2'b00, 2'b01, 1'b1, 2'b00);

    do_reset();
    start_frame(5'd3, L0, 3'd0, '0, 3'd4);
    pixel(UP_B, 24'h3A3A3A);
    end_frame("e3", 2'b00, 2'b00, 1'b0, 2'b00);

    do_reset();
    start_frame(5'd4, L0, 3'd0, '0, 3'd4);
    pixel(UP_B, 24'h121428);
    end_frame("e4a", 2'b00, 2'b00, 1'b0, 2'b00);

    do_reset();
    start_frame(5'd4, L0, 3'd0, '0, 3'd4);
    pixel(UP_B, 24'hFFFFFF);
    end_frame("e4b", 2'b00, 2'b01, 1'b1, 2'b00);

    do_reset();
    start_frame(5'd7, L0, 3'd0, '0, 3'd4);
    pixel(UP_A, 24'hFFFFFF);
    end_frame("f", 2'b00, 2'b00, 1'b0, 2'b00);

    // right-facing bike1 and hit thresholding
    do_reset();
    start_frame(5'd0, '0, 3'd4, L0, 3'd3);
    pixel(RT_A, 24'hFFFFFF);
    end_frame("g1", 2'b00, 2'b10, 1'b1, 2'b00);
    check("g1_t2", 32'(collided_t2), 32'd0);

    do_reset();
    start_frame(5'd0, '0, 3'd4, L0, 3'd3);
    pixel(RT_A, 24'hFFFFFF);
    pixel(RT_B, 24'hFFFFFF);
    end_frame("g2", 2'b00, 2'b10, 1'b1, 2'b00);
    check("g2_t2", 32'(collided_t2), 32'd2);
    check("g2_nw", 32'(collided_nw), 32'd2);

    do_reset();
    start_frame(5'd0, '0, 3'd4, L0, 3'd3);
    pixel(RT_A, 24'hFFFFFF);
    pixel(RT_A, 24'h00FF00);
    end_frame("g3", 2'b00, 2'b10, 1'b1, 2'b00);
    check("g3_t2", 32'(collided_t2), 32'd2);

    // probes above the top and below the bottom of the arena
    do_reset();
    start_frame(5'd0, WALL_UP, 3'd0, WALL_DN, 3'd2);
    end_frame("h", 2'b00, 2'b11, 1'b1, 2'b00);
    check("h_nw", 32'(collided_nw), 32'd0);
    check("h_t2", 32'(collided_t2), 32'd3);

    // both bikes in one frame, clear of bit0 coinciding with its set
    do_reset();
    start_frame(5'd0, L0, 3'd0, L0, 3'd3);
    pixel(UP_A, 24'hFFFFFF);
    pixel(RT_A, 24'hFFFFFF);
    end_frame("i", 2'b00, 2'b11, 1'b1, 2'b01);
    clear_collided = 2'b01;
    @(negedge clock);
    clear_collided = '0;
    check("i_clear", 32'(collided), 32'd2);
    check("i_clear_pulse", 32'(crash_pulse), 32'd0);

    // already-set bit gives no pulse; pixel in the frame_end cycle counts
    start_frame(5'd0, L0, 3'd0, L0, 3'd3);
    pixel(RT_B, 24'hFFFFFF);
    end_frame("i_again", 2'b10, 2'b10, 1'b0, 2'b00);

    start_frame(5'd0, L0, 3'd0, L0, 3'd3);
    pix_valid = 1'b1;
    addr      = UP_B;
    pix_data  = 24'hFFFFFF;
    end_frame("j_lastpix", 2'b10, 2'b11, 1'b1, 2'b00);

    // reset in the middle of a frame after a hit
    do_reset();
    start_frame(5'd0, L0, 3'd0, '0, 3'd4);
    pixel(UP_A, 24'hFFFFFF);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("k_busy", 32'(busy), 32'd0);
    frame_end = 1'b1;
    @(negedge clock);
    frame_end = 1'b0;
    check("k_fe_idle", 32'(busy), 32'd0);
    @(negedge clock);
    check("k_col", 32'(collided), 32'd0);
    check("k_pulse", 32'(crash_pulse), 32'd0);
    @(negedge clock);
    check("k_col_late", 32'(collided), 32'd0);
    check("k_pulse_late", 32'(crash_pulse), 32'd0);

    // restart discards the partial frame
    do_reset();
    start_frame(5'd0, L0, 3'd0, '0, 3'd4);
    pixel(UP_A, 24'hFFFFFF);
    start_frame(5'd0, L0, 3'd0, '0, 3'd4);
    end_frame("l", 2'b00, 2'b00, 1'b0, 2'b00);

    // frame_start and frame_end together: restart wins
    do_reset();
    start_frame(5'd0, L0, 3'd0, '0, 3'd4);
    pixel(UP_A, 24'hFFFFFF);
    frame_start = 1'b1;
    frame_end   = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    frame_end   = 1'b0;
    check("m_still_scan", 32'(busy), 32'd1);
    @(negedge clock);
    check("m_no_eval", 32'(collided), 32'd0);
    end_frame("m", 2'b00, 2'b00, 1'b0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bgr_collision_monitor.md
Name: bgr_collision_monitor

Overview:
- Parametrised, clocked collision monitor for N bikes.
- Sits on the VGA pixel-fetch path: watches the pixel address/colour stream each frame and checks two probe points per bike against the selected background colour. Probes lie ahead of each bike's nose.
- Accumulates hits over a frame and evaluates them at frame end. Publishes sticky per-bike collision flags plus a one-cycle crash pulse to game control.
- Adds multi-bike support, hit thresholding and arena-wall detection.

Parameters:
- NUM_BIKES, 2, number of bikes monitored (1..4).
- ADDR_W, 19, pixel address width.
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- PROBE_AHEAD, 16, probe distance ahead of bike centre (pixels/lines).
- PROBE_SIDE, 5, lateral probe offset from centre.
- HIT_THRESH, 1, probe hits per frame needed to declare a collision (1..15).
- WALL_IS_CRASH, 1, 1 = an off-screen probe counts as a collision.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- background  in  5  background select 0..4
- frame_start  in  1  one-cycle pulse before first pixel of frame
- frame_end  in  1  one-cycle pulse, coincident with or after last pixel
- pix_valid  in  1  addr/data valid this cycle
- addr  in  ADDR_W  current pixel address
- pix_data  in  24  current pixel RGB
- bike_loc  in  NUM_BIKES*ADDR_W  flattened bike centre addresses, bike i at [i*ADDR_W +: ADDR_W]
- bike_orient  in  NUM_BIKES*3  0 up, 1 left, 2 down, 3 right, 4..7 inactive
- clear_collided  in  NUM_BIKES  per-bike clear of sticky flag
- collided  out  NUM_BIKES  sticky collision flags
- crash_pulse  out  1  one-cycle pulse when any flag newly sets
- busy  out  1  high in SCAN and EVAL

Behaviour:
- Reset: collided=0, crash_pulse=0, busy=0, all hit counters 0, state IDLE.
- Background colour table: 0,1→000000; 2→0C1530; 3→3A3A3A; 4→121428; 5..31→no pixel is ever "foreign".
- A pixel is foreign when pix_data differs from the selected background colour.
- Snapshot: on frame_start, latch bike_loc, bike_orient and background. Compute both probes per bike from the latched values, in signed ADDR_W+2 arithmetic, with A=PROBE_AHEAD and S=PROBE_SIDE:
  - up: loc−S−A·H and loc+S−A·H
  - left: loc−A−S·H and loc−A+S·H
  - down: loc+S+A·H and loc−S+A·H
  - right: loc+A−S·H and loc+A+S·H
- Input changes during a frame are ignored until the next frame_start.
- Wall: a probe <0 or ≥H_RES·V_RES is off-screen.
  - WALL_IS_CRASH=1: that bike's counter is forced to HIT_THRESH at snapshot.
  - WALL_IS_CRASH=0: the probe is dead.
- Inactive bikes (orient 4..7) have no probes and never collide.
- FSM:
  - IDLE: frame_start → SCAN (snapshot, counters cleared).
  - SCAN: pix_valid with addr == an active probe and foreign pixel → counter +1, saturating at 15. Two probe matches in one cycle (impossible for distinct probes) count once.
  - SCAN: frame_end → EVAL. A pixel valid in the frame_end cycle is counted.
  - SCAN: frame_start again → restart SCAN (partial frame discarded, new snapshot). frame_start and frame_end together in SCAN: frame_start wins.
  - EVAL: one cycle. For bike i, count ≥ HIT_THRESH sets collided[i]. → IDLE.
- Frame_end in IDLE is ignored.
- Latency: frame_end at cycle T → collided/crash_pulse visible at T+2. crash_pulse is high for exactly one cycle only if at least one bit went 0→1.
- clear_collided[i] clears the bit next cycle. If a clear coincides with the EVAL set of the same bit, set wins and crash_pulse fires.
- Reset asserted mid-SCAN/EVAL: immediate return to IDLE next edge, all flags and counters cleared, no pulse.

Test Plan:
- Bike0 loc=64320 (row100,col320), orient 0, bg 0; frame with pixel addr 54075 data FFFFFF, frame_end at T → collided=01 at T+2, crash_pulse high one cycle.
- Same setup, pixel 54075 data 000000 → collided stays 00, no pulse. Repeat with bg=2 and data 0C1530 → no hit; data 000000 → hit.
- HIT_THRESH=2, bike1 orient 3 loc=64320: probes 61136 and 67536. Hit only 61136 → no flag. Hit both → collided=10.
- Bike0 loc=5*640+320 orient 0 (up probe negative), WALL_IS_CRASH=1, no foreign pixels → collided[0]=1 after frame_end. Same with WALL_IS_CRASH=0 → 0.
- Both bikes hit in same frame → collided=11, a single crash_pulse. clear_collided=01 in the EVAL-set cycle for bike0 → bit0 still 1.
- Reset asserted mid-SCAN after a hit, then frame_end → collided=00, busy=0, no pulse. frame_start twice before frame_end → first-frame hits discarded.
